sequence_pattern_generator: RTL and testbench

- Serial bit-pattern transmitter. The counterpart of the team's serial sequence detectors.
- On a start pulse, shifts a PAT_W-bit pattern out MSB-first, one bit per clock.
- Repeats the pattern a programmed number of times, with an optional idle gap between frames.
- Drives detector input_data in block-level benches and self-test paths.

---
 rtl/seq_gen_pkg.sv | 14 +
 rtl/seq_gen_shifter.sv | 36 +++
 rtl/sequence_pattern_generator.sv | 139 +++++++++++++
 tb/tb_sequence_pattern_generator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial sequence generator and its detector benches.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } seq_state_t;

    localparam int         DEF_PAT_W   = 5;
    localparam logic [4:0] DEF_PATTERN = 5'b10101;

endpackage

// File: rtl/seq_gen_shifter.sv
// Loadable MSB-first shift register with a bit-position counter for one frame.
module seq_gen_shifter #(
    parameter int PAT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_value,
    output logic             shift_bit,
    output logic             last_bit
);

    localparam int BC_W = $clog2(PAT_W);

    logic [PAT_W-1:0] shreg;
    logic [BC_W-1:0]  bit_cnt;

    // load wins over shift so a frame can be reloaded on its own last bit
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= load_value;
            bit_cnt <= '0;
        end else if (shift) begin
            shreg   <= {shreg[PAT_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign shift_bit = shreg[PAT_W-1];
    assign last_bit  = (bit_cnt == BC_W'(PAT_W - 1));

endmodule

// File: rtl/sequence_pattern_generator.sv
// Serial pattern transmitter: repeats a PAT_W-bit frame MSB-first with optional idle gaps.
// Define SEQ_GEN_PROG_PATTERN_EN to add a pattern_in port sampled with start.
module sequence_pattern_generator
    import seq_gen_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               CNT_W   = 8,
    parameter int               GAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_count,
    input  logic [GAP_W-1:0] gap_cycles,
`ifdef SEQ_GEN_PROG_PATTERN_EN
    input  logic [PAT_W-1:0] pattern_in,
`endif
    output logic             serial_out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             all_done
);

    seq_state_t       state;
    logic [CNT_W-1:0] frames_left;
    logic [GAP_W-1:0] gap_reg;
    logic [GAP_W-1:0] gap_cnt;
    logic             accept;
    logic             reload_send;
    logic             reload_gap;
    logic             sh_load;
    logic             sh_shift;
    logic             shift_bit;
    logic             last_bit;
    logic [PAT_W-1:0] load_value;

    // all_done is high during the DONE cycle seen externally, so a start there is dropped
    assign accept      = start && (repeat_count != '0) && !all_done;
    assign reload_send = last_bit && (frames_left != CNT_W'(1)) && (gap_reg == '0);
    assign reload_gap  = (gap_cnt == GAP_W'(1));

    always_comb begin
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        case (state)
            IDLE: sh_load = accept;
            SEND: begin
                sh_shift = 1'b1;
                sh_load  = reload_send;
            end
            GAP:  sh_load = reload_gap;
            default: ;
        endcase
    end

`ifdef SEQ_GEN_PROG_PATTERN_EN
    logic [PAT_W-1:0] pat_reg;

    always_ff @(posedge clk) begin
        if (reset)
            pat_reg <= '0;
        else if (state == IDLE && accept)
            pat_reg <= pattern_in;
    end

    assign load_value = (state == IDLE) ? pattern_in : pat_reg;
`else
    assign load_value = PATTERN;
`endif

    seq_gen_shifter #(.PAT_W(PAT_W)) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load       (sh_load),
        .shift      (sh_shift),
        .load_value (load_value),
        .shift_bit  (shift_bit),
        .last_bit   (last_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            frames_left <= '0;
            gap_reg     <= '0;
            gap_cnt     <= '0;
            serial_out  <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            all_done    <= 1'b0;
        end else begin
            serial_out <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            all_done   <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (accept) begin
                        frames_left <= repeat_count;
                        gap_reg     <= gap_cycles;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    serial_out <= shift_bit;
                    out_valid  <= 1'b1;
                    busy       <= 1'b1;
                    if (last_bit) begin
                        frame_done  <= 1'b1;
                        frames_left <= frames_left - 1'b1;
                        if (frames_left == CNT_W'(1)) begin
                            state <= DONE;
                        end else if (gap_reg != '0) begin
                            gap_cnt <= gap_reg;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    busy    <= 1'b1;
                    gap_cnt <= gap_cnt - 1'b1;
                    if (reload_gap)
                        state <= SEND;
                end
                DONE: begin
                    busy     <= 1'b0;
                    all_done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_pattern_generator.sv
// Randomized self-checking bench for sequence_pattern_generator against a cycle-stream model.
module tb_sequence_pattern_generator;

    localparam int         PAT_W   = 5;
    localparam int         CNT_W   = 8;
    localparam int         GAP_W   = 4;
    localparam logic [4:0] DEF_PAT = 5'b10101;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] repeat_count = '0;
    logic [GAP_W-1:0] gap_cycles = '0;
`ifdef SEQ_GEN_PROG_PATTERN_EN
    logic [PAT_W-1:0] pattern_in = '0;
`endif
    logic serial_out, out_valid, busy, frame_done, all_done;
    logic [4:0] obs;

    int vectors = 0;
    int miscompares = 0;
    // expected {serial_out, out_valid, busy, frame_done, all_done} per cycle after start edge
    logic [4:0] exp_q[$];

    sequence_pattern_generator #(
        .PAT_W(PAT_W), .PATTERN(DEF_PAT), .CNT_W(CNT_W), .GAP_W(GAP_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .repeat_count(repeat_count), .gap_cycles(gap_cycles),
`ifdef SEQ_GEN_PROG_PATTERN_EN
        .pattern_in(pattern_in),
`endif
        .serial_out(serial_out), .out_valid(out_valid), .busy(busy),
        .frame_done(frame_done), .all_done(all_done)
    );

    assign obs = {serial_out, out_valid, busy, frame_done, all_done};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic model_burst(input int rc, input int g, input logic [4:0] pat);
        exp_q.delete();
        for (int f = 0; f < rc; f++) begin
            for (int i = 0; i < PAT_W; i++)
                exp_q.push_back({pat[PAT_W-1-i], 1'b1, 1'b1, (i == PAT_W-1), 1'b0});
            if (f < rc - 1)
                for (int j = 0; j < g; j++) exp_q.push_back(5'b00100);
        end
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00000);
    endtask

    task automatic send_start(input int rc, input int g, input logic [4:0] pat);
        @(negedge clk);
        start = 1'b1;
        repeat_count = rc[CNT_W-1:0];
        gap_cycles = g[GAP_W-1:0];
`ifdef SEQ_GEN_PROG_PATTERN_EN
        pattern_in = pat;
`endif
        @(negedge clk);
        start = 1'b0;
        repeat_count = CNT_W'($urandom);
        gap_cycles = GAP_W'($urandom);
`ifdef SEQ_GEN_PROG_PATTERN_EN
        pattern_in = PAT_W'($urandom);
`else
        if (pat !== DEF_PAT) $display("note: fixed pattern build ignores %b", pat);
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        repeat_count = 8'd1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== 5'b0) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got %b expected %b", k, obs, 5'b0);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_release: got %b expected %b", obs, 5'b0);
        end
    endtask

    task automatic test_single_frame();
        model_burst(1, 0, DEF_PAT);
        send_start(1, 0, DEF_PAT);
        vectors++;
        if (obs !== 5'b0) begin
            miscompares++;
            $display("FAIL single_launch: got %b expected %b", obs, 5'b0);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_q[k]) begin
                miscompares++;
                $display("FAIL single_frame cyc %0d: got %b expected %b", k, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        model_burst(2, 0, DEF_PAT);
        send_start(2, 0, DEF_PAT);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_q[k]) begin
                miscompares++;
                $display("FAIL back_to_back cyc %0d: got %b expected %b", k, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_gap();
        int busy_cycles;
        busy_cycles = 0;
        model_burst(3, 2, DEF_PAT);
        send_start(3, 2, DEF_PAT);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            vectors++;
            if (obs !== exp_q[k]) begin
                miscompares++;
                $display("FAIL gap cyc %0d: got %b expected %b", k, obs, exp_q[k]);
            end
        end
        vectors++;
        if (busy_cycles != 3 * PAT_W + 2 * 2) begin
            miscompares++;
            $display("FAIL gap_busy_len: got %0d expected %0d", busy_cycles, 3 * PAT_W + 4);
        end
    endtask

    task automatic test_ignored_start();
        // repeat_count of zero must produce nothing
        @(negedge clk);
        start = 1'b1;
        repeat_count = '0;
        gap_cycles = GAP_W'($urandom);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== 5'b0) begin
                miscompares++;
                $display("FAIL zero_count cyc %0d: got %b expected %b", k, obs, 5'b0);
            end
        end
        // re-pulses mid-burst and during the all_done cycle are dropped
        model_burst(2, 0, DEF_PAT);
        for (int j = 0; j < 6; j++) exp_q.push_back(5'b00000);
        send_start(2, 0, DEF_PAT);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_q[k]) begin
                miscompares++;
                $display("FAIL ignored_start cyc %0d: got %b expected %b", k, obs, exp_q[k]);
            end
            start = (k == 2 || k == 4 || k == 10);
            repeat_count = 8'd3;
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        model_burst(4, int'($urandom_range(0, 3)), DEF_PAT);
        send_start(4, 0, DEF_PAT);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_q[k]) begin
                miscompares++;
                $display("FAIL reset_mid_pre cyc %0d: got %b expected %b", k, obs, exp_q[k]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (obs !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_mid_abort: got %b expected %b", obs, 5'b0);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_mid_quiet cyc %0d: got %b expected %b", k, obs, 5'b0);
            end
        end
        model_burst(1, 0, DEF_PAT);
        send_start(1, 0, DEF_PAT);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_q[k]) begin
                miscompares++;
                $display("FAIL reset_mid_restart cyc %0d: got %b expected %b", k, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        int rc, g;
        logic [4:0] pat;
        for (int n = 0; n < 9; n++) begin
            rc = (n == 0) ? 255 : int'($urandom_range(1, 4));
            g  = (n == 0) ? 1 : int'($urandom_range(0, 3));
`ifdef SEQ_GEN_PROG_PATTERN_EN
            pat = 5'($urandom);
`else
            pat = DEF_PAT;
`endif
            model_burst(rc, g, pat);
            send_start(rc, g, pat);
            for (int k = 0; k < exp_q.size(); k++) begin
                @(negedge clk);
                vectors++;
                if (obs !== exp_q[k]) begin
                    miscompares++;
                    $display("FAIL random n%0d rc%0d g%0d cyc %0d: got %b expected %b",
                             n, rc, g, k, obs, exp_q[k]);
                end
                repeat_count = CNT_W'($urandom);
                gap_cycles = GAP_W'($urandom);
            end
        end
    endtask

`ifdef SEQ_GEN_PROG_PATTERN_EN
    task automatic test_prog_pattern();
        model_burst(1, 0, 5'b11001);
        send_start(1, 0, 5'b11001);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_q[k]) begin
                miscompares++;
                $display("FAIL prog_pattern cyc %0d: got %b expected %b", k, obs, exp_q[k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gap();
        test_ignored_start();
        test_reset_mid();
        test_random();
`ifdef SEQ_GEN_PROG_PATTERN_EN
        test_prog_pattern();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
